// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access sizes, write-back selects,
// fault codes and the memory-stage FSM state type.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [1:0] WB_PC  = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_ILLEGAL  = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_FAULT_WB = 2'd2
    } state_e;

    // Natural alignment check on the two low byte-offset bits.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane formatting: store replication / byte enables and
// load lane extraction with sign or zero extension.
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    localparam int NB = DATA_W / 8,
    localparam int LW = $clog2(NB)
) (
    input  logic [1:0]        i_st_size,
    input  logic [LW-1:0]     i_st_lane,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [DATA_W-1:0] o_wdata,
    output logic [NB-1:0]     o_be,
    input  logic [1:0]        i_ld_size,
    input  logic [LW-1:0]     i_ld_lane,
    input  logic              i_ld_sext,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [LW-1:0] w_hoff;

    // Store path: replicate the store data across lanes and build byte enables.
    always_comb begin
        o_wdata = '0;
        o_be    = '0;
        case (i_st_size)
            SZ_BYTE: begin
                o_wdata = {NB{i_st_data[7:0]}};
                o_be    = NB'(1'b1) << i_st_lane;
            end
            SZ_HALF: begin
                o_wdata = {(NB/2){i_st_data[15:0]}};
                o_be    = NB'(2'b11) << i_st_lane;
            end
            SZ_WORD: begin
                o_wdata = i_st_data;
                o_be    = '1;
            end
            default: begin
                o_wdata = '0;
                o_be    = '0;
            end
        endcase
    end

    // Load path: pick the addressed lane, then fill the upper bits with the sign or zeros.
    always_comb begin
        w_hoff    = i_ld_lane;
        w_hoff[0] = 1'b0;
        w_byte    = i_rdata[i_ld_lane*8 +: 8];
        w_half    = i_rdata[w_hoff*8 +: 16];
        o_ld_data = '0;
        case (i_ld_size)
            SZ_BYTE: begin
                o_ld_data      = {DATA_W{i_ld_sext & w_byte[7]}};
                o_ld_data[7:0] = w_byte;
            end
            SZ_HALF: begin
                o_ld_data       = {DATA_W{i_ld_sext & w_half[15]}};
                o_ld_data[15:0] = w_half;
            end
            SZ_WORD: begin
                o_ld_data = i_rdata;
            end
            default: begin
                o_ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Pipeline memory stage: issues req/ack accesses to a variable-latency data
// memory, formats loads, registers the write-back value and reports faults.
module mem_stage_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15,
    localparam int NB     = DATA_W / 8,
    localparam int LW     = $clog2(NB),
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] store_reg,
    input  logic [DATA_W-1:0] pc_link,
    input  logic              data_src,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [1:0]        wb_sel,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [NB-1:0]     mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [1:0]        fault_code
);

    state_e              r_state, w_state_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [NB-1:0]       r_mem_be, w_mem_be_nxt;
    logic                r_wb_valid, w_wb_valid_nxt;
    logic [DATA_W-1:0]   r_wb_data, w_wb_data_nxt;
    logic                r_fault, w_fault_nxt;
    logic [1:0]          r_fault_code, w_fault_code_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    // Command captured at issue so completion does not depend on the held bundle.
    logic [1:0]          r_cmd_wbsel, w_cmd_wbsel_nxt;
    logic [1:0]          r_cmd_size, w_cmd_size_nxt;
    logic                r_cmd_sext, w_cmd_sext_nxt;
    logic                r_cmd_load, w_cmd_load_nxt;
    logic [LW-1:0]       r_cmd_lane, w_cmd_lane_nxt;
    logic [DATA_W-1:0]   r_cmd_wbval, w_cmd_wbval_nxt;

    logic                w_mem_op;
    logic                w_illegal;
    logic                w_misaligned;
    logic [DATA_W-1:0]   w_st_data;
    logic [DATA_W-1:0]   w_st_wdata;
    logic [NB-1:0]       w_st_be;
    logic [DATA_W-1:0]   w_ld_data;
    logic [DATA_W-1:0]   w_wb_direct;
    logic [DATA_W-1:0]   w_wb_done;
    logic [ADDR_W-1:0]   w_addr_aligned;

    assign w_mem_op     = mem_rd | mem_wr;
    assign w_illegal    = (mem_rd & mem_wr) | (size == SZ_ILL) | ((size == SZ_WORD) && (DATA_W == 16));
    assign w_misaligned = is_misaligned(size, alu_result[1:0]);
    assign w_st_data    = data_src ? store_reg : immediate;

    mem_lane_fmt #(
        .DATA_W (DATA_W)
    ) u_lane_fmt (
        .i_st_size (size),
        .i_st_lane (alu_result[LW-1:0]),
        .i_st_data (w_st_data),
        .o_wdata   (w_st_wdata),
        .o_be      (w_st_be),
        .i_ld_size (r_cmd_size),
        .i_ld_lane (r_cmd_lane),
        .i_ld_sext (r_cmd_sext),
        .i_rdata   (mem_rdata),
        .o_ld_data (w_ld_data)
    );

    // Word-aligned address and write-back values for direct and completed ops.
    always_comb begin
        w_addr_aligned           = alu_result;
        w_addr_aligned[LW-1:0]   = '0;
        case (wb_sel)
            WB_PC:   w_wb_direct = pc_link;
            WB_ALU:  w_wb_direct = DATA_W'(alu_result);
            default: w_wb_direct = '0;
        endcase
        if (r_cmd_wbsel[1]) begin
            w_wb_done = r_cmd_load ? w_ld_data : '0;
        end else begin
            w_wb_done = r_cmd_wbval;
        end
    end

    assign stall = (r_state == ST_ACCESS) || ((r_state == ST_IDLE) && in_valid && w_mem_op);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_be_nxt     = r_mem_be;
        w_wb_valid_nxt   = 1'b0;
        w_wb_data_nxt    = r_wb_data;
        w_fault_nxt      = 1'b0;
        w_fault_code_nxt = r_fault_code;
        w_cnt_nxt        = r_cnt;
        w_cmd_wbsel_nxt  = r_cmd_wbsel;
        w_cmd_size_nxt   = r_cmd_size;
        w_cmd_sext_nxt   = r_cmd_sext;
        w_cmd_load_nxt   = r_cmd_load;
        w_cmd_lane_nxt   = r_cmd_lane;
        w_cmd_wbval_nxt  = r_cmd_wbval;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && w_mem_op) begin
                    if (w_illegal || w_misaligned) begin
                        w_state_nxt      = ST_FAULT_WB;
                        w_fault_nxt      = 1'b1;
                        w_fault_code_nxt = w_illegal ? FC_ILLEGAL : FC_MISALIGN;
                        w_wb_valid_nxt   = 1'b1;
                        w_wb_data_nxt    = '0;
                    end else begin
                        w_state_nxt      = ST_ACCESS;
                        w_mem_req_nxt    = 1'b1;
                        w_mem_we_nxt     = mem_wr;
                        w_mem_addr_nxt   = w_addr_aligned;
                        w_mem_wdata_nxt  = w_st_wdata;
                        w_mem_be_nxt     = w_st_be;
                        w_cnt_nxt        = '0;
                        w_cmd_wbsel_nxt  = wb_sel;
                        w_cmd_size_nxt   = size;
                        w_cmd_sext_nxt   = sign_ext;
                        w_cmd_load_nxt   = mem_rd;
                        w_cmd_lane_nxt   = alu_result[LW-1:0];
                        w_cmd_wbval_nxt  = w_wb_direct;
                    end
                end else if (in_valid) begin
                    w_wb_valid_nxt = 1'b1;
                    w_wb_data_nxt  = w_wb_direct;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (mem_ack) begin
                    w_state_nxt    = ST_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_data_nxt  = w_wb_done;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt      = ST_IDLE;
                    w_mem_req_nxt    = 1'b0;
                    w_mem_we_nxt     = 1'b0;
                    w_fault_nxt      = 1'b1;
                    w_fault_code_nxt = FC_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                end
            end
            ST_FAULT_WB: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_cnt        <= '0;
            r_cmd_wbsel  <= WB_PC;
            r_cmd_size   <= SZ_BYTE;
            r_cmd_sext   <= 1'b0;
            r_cmd_load   <= 1'b0;
            r_cmd_lane   <= '0;
            r_cmd_wbval  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_be     <= w_mem_be_nxt;
            r_wb_valid   <= w_wb_valid_nxt;
            r_wb_data    <= w_wb_data_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cmd_wbsel  <= w_cmd_wbsel_nxt;
            r_cmd_size   <= w_cmd_size_nxt;
            r_cmd_sext   <= w_cmd_sext_nxt;
            r_cmd_load   <= w_cmd_load_nxt;
            r_cmd_lane   <= w_cmd_lane_nxt;
            r_cmd_wbval  <= w_cmd_wbval_nxt;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: a 16-bit instance (TIMEOUT=4) and a
// 32-bit instance share clock and reset.
module tb_mem_stage_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_valid, a_dsrc, a_rd, a_wr, a_sext, a_ack;
    logic [15:0] a_alu, a_imm, a_sreg, a_pc, a_rdata;
    logic [1:0]  a_size, a_wbsel;
    logic        a_stall, a_req, a_we, a_wbv, a_fault;
    logic [15:0] a_addr, a_wdata, a_wbd;
    logic [1:0]  a_be, a_fc;

    logic        b_in_valid, b_dsrc, b_rd, b_wr, b_sext, b_ack;
    logic [15:0] b_alu;
    logic [31:0] b_imm, b_sreg, b_pc, b_rdata;
    logic [1:0]  b_size, b_wbsel;
    logic        b_stall, b_req, b_we, b_wbv, b_fault;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_wbd;
    logic [3:0]  b_be;
    logic [1:0]  b_fc;

    mem_stage_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) u16 (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .alu_result(a_alu),
        .immediate(a_imm), .store_reg(a_sreg), .pc_link(a_pc), .data_src(a_dsrc),
        .mem_rd(a_rd), .mem_wr(a_wr), .size(a_size), .sign_ext(a_sext), .wb_sel(a_wbsel),
        .stall(a_stall), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_be(a_be), .mem_ack(a_ack), .mem_rdata(a_rdata),
        .wb_valid(a_wbv), .wb_data(a_wbd), .fault(a_fault), .fault_code(a_fc)
    );

    mem_stage_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(4)) u32 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .alu_result(b_alu),
        .immediate(b_imm), .store_reg(b_sreg), .pc_link(b_pc), .data_src(b_dsrc),
        .mem_rd(b_rd), .mem_wr(b_wr), .size(b_size), .sign_ext(b_sext), .wb_sel(b_wbsel),
        .stall(b_stall), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_be(b_be), .mem_ack(b_ack), .mem_rdata(b_rdata),
        .wb_valid(b_wbv), .wb_data(b_wbd), .fault(b_fault), .fault_code(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [1:0] ws, input logic [15:0] alu, input logic ds,
                           input logic [15:0] imm, input logic [15:0] sreg, input logic [15:0] pc);
        a_in_valid = 1'b1; a_rd = rd; a_wr = wr; a_size = sz; a_sext = sx; a_wbsel = ws;
        a_alu = alu; a_dsrc = ds; a_imm = imm; a_sreg = sreg; a_pc = pc;
    endtask

    task automatic b_issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [1:0] ws, input logic [15:0] alu, input logic [31:0] sreg);
        b_in_valid = 1'b1; b_rd = rd; b_wr = wr; b_size = sz; b_sext = sx; b_wbsel = ws;
        b_alu = alu; b_dsrc = 1'b1; b_imm = 32'h0; b_sreg = sreg; b_pc = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        a_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
        a_in_valid = 1'b0; a_ack = 1'b0; a_rdata = 16'h0;
        b_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0, 32'h0);
        b_in_valid = 1'b0; b_ack = 1'b0; b_rdata = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'h0, a_req}, 32'h0);
        chk("rst_wbv", {31'h0, a_wbv}, 32'h0);
        chk("rst_wbd", {16'h0, a_wbd}, 32'h0);
        chk("rst_fc", {30'h0, a_fc}, 32'h0);
        chk("rst_stall", {31'h0, a_stall}, 32'h0);
        chk("rst_b_wbd", b_wbd, 32'h0);

        // 1: byte load 0x0101, sign-extended, ack in third access cycle
        reset = 1'b1;
        a_issue(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 16'h0101, 1'b0, 16'h0, 16'h0, 16'h0);
        #1 chk("t1_stall_issue", {31'h0, a_stall}, 32'h1);
        tick(); a_in_valid = 1'b0;
        chk("t1_req", {31'h0, a_req}, 32'h1);
        chk("t1_addr", {16'h0, a_addr}, 32'h0100);
        chk("t1_we", {31'h0, a_we}, 32'h0);
        chk("t1_stall_a1", {31'h0, a_stall}, 32'h1);
        tick(); chk("t1_stall_a2", {31'h0, a_stall}, 32'h1);
        tick(); chk("t1_stall_a3", {31'h0, a_stall}, 32'h1);
        a_ack = 1'b1; a_rdata = 16'h80AA;
        tick(); a_ack = 1'b0;
        chk("t1_wbv", {31'h0, a_wbv}, 32'h1);
        chk("t1_wbd", {16'h0, a_wbd}, 32'hFF80);
        chk("t1_req_drop", {31'h0, a_req}, 32'h0);
        #1 chk("t1_stall_done", {31'h0, a_stall}, 32'h0);
        tick(); chk("t1_wbv_pulse", {31'h0, a_wbv}, 32'h0);

        // 2: half store then byte store
        a_issue(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 16'h0010, 1'b1, 16'h0, 16'h1234, 16'h0);
        tick(); a_in_valid = 1'b0;
        chk("t2h_be", {30'h0, a_be}, 32'h3);
        chk("t2h_wdata", {16'h0, a_wdata}, 32'h1234);
        chk("t2h_we", {31'h0, a_we}, 32'h1);
        chk("t2h_addr", {16'h0, a_addr}, 32'h0010);
        a_ack = 1'b1;
        tick(); a_ack = 1'b0;
        chk("t2h_wbv", {31'h0, a_wbv}, 32'h1);
        chk("t2h_wbd", {16'h0, a_wbd}, 32'h0010);
        a_issue(1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 16'h0011, 1'b0, 16'h00CD, 16'h1234, 16'h0);
        tick(); a_in_valid = 1'b0;
        chk("t2b_be", {30'h0, a_be}, 32'h2);
        chk("t2b_wdata", {16'h0, a_wdata}, 32'hCDCD);
        chk("t2b_addr", {16'h0, a_addr}, 32'h0010);
        a_ack = 1'b1;
        tick(); a_ack = 1'b0;
        chk("t2b_wbd", {16'h0, a_wbd}, 32'h0011);

        // 3: misaligned half load, then word access on a 16-bit datapath
        a_issue(1'b1, 1'b0, 2'd1, 1'b1, 2'd2, 16'h0003, 1'b0, 16'h0, 16'h0, 16'h0);
        #1 chk("t3_stall_issue", {31'h0, a_stall}, 32'h1);
        tick(); a_in_valid = 1'b0;
        #1;
        chk("t3_fault", {31'h0, a_fault}, 32'h1);
        chk("t3_fc", {30'h0, a_fc}, 32'h1);
        chk("t3_wbv", {31'h0, a_wbv}, 32'h1);
        chk("t3_wbd", {16'h0, a_wbd}, 32'h0);
        chk("t3_req", {31'h0, a_req}, 32'h0);
        chk("t3_stall_fwb", {31'h0, a_stall}, 32'h0);
        tick();
        chk("t3_fault_pulse", {31'h0, a_fault}, 32'h0);
        chk("t3_wbv_pulse", {31'h0, a_wbv}, 32'h0);
        chk("t3_fc_hold", {30'h0, a_fc}, 32'h1);
        a_issue(1'b1, 1'b0, 2'd2, 1'b0, 2'd2, 16'h0004, 1'b0, 16'h0, 16'h0, 16'h0);
        tick(); a_in_valid = 1'b0;
        chk("t3w_fault", {31'h0, a_fault}, 32'h1);
        chk("t3w_fc", {30'h0, a_fc}, 32'h2);
        chk("t3w_req", {31'h0, a_req}, 32'h0);
        tick();

        // 4: timeout with no ack, then ack in the final wait cycle
        a_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0);
        tick(); a_in_valid = 1'b0;
        chk("t4_req_a1", {31'h0, a_req}, 32'h1);
        tick(); tick(); tick();
        chk("t4_req_a4", {31'h0, a_req}, 32'h1);
        chk("t4_nofault_a4", {31'h0, a_fault}, 32'h0);
        tick();
        chk("t4_req_drop", {31'h0, a_req}, 32'h0);
        chk("t4_fault", {31'h0, a_fault}, 32'h1);
        chk("t4_fc", {30'h0, a_fc}, 32'h3);
        chk("t4_wbv", {31'h0, a_wbv}, 32'h0);
        chk("t4_stall", {31'h0, a_stall}, 32'h0);
        tick();
        chk("t4_fault_pulse", {31'h0, a_fault}, 32'h0);
        a_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0);
        a_rdata = 16'h1234;
        tick(); a_in_valid = 1'b0;
        tick(); tick(); tick();
        a_ack = 1'b1;
        tick(); a_ack = 1'b0;
        chk("t4a_wbv", {31'h0, a_wbv}, 32'h1);
        chk("t4a_wbd", {16'h0, a_wbd}, 32'h0034);
        chk("t4a_fault", {31'h0, a_fault}, 32'h0);
        chk("t4a_req", {31'h0, a_req}, 32'h0);
        chk("t4a_fc_hold", {30'h0, a_fc}, 32'h3);

        // 5: back-to-back non-memory ops
        a_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0042);
        #1 chk("t5_stall0", {31'h0, a_stall}, 32'h0);
        tick();
        a_wbsel = 2'd1; a_alu = 16'h1000;
        chk("t5_wbv0", {31'h0, a_wbv}, 32'h1);
        chk("t5_wbd0", {16'h0, a_wbd}, 32'h0042);
        #1 chk("t5_stall1", {31'h0, a_stall}, 32'h0);
        tick(); a_in_valid = 1'b0;
        chk("t5_wbv1", {31'h0, a_wbv}, 32'h1);
        chk("t5_wbd1", {16'h0, a_wbd}, 32'h1000);
        tick();
        chk("t5_wbv_end", {31'h0, a_wbv}, 32'h0);

        // 6: reset during an access, late ack ignored
        a_issue(1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 16'h0002, 1'b0, 16'h0, 16'h0, 16'h0);
        tick(); a_in_valid = 1'b0;
        chk("t6_req", {31'h0, a_req}, 32'h1);
        reset = 1'b0;
        tick();
        chk("t6_rst_req", {31'h0, a_req}, 32'h0);
        chk("t6_rst_stall", {31'h0, a_stall}, 32'h0);
        chk("t6_rst_wbv", {31'h0, a_wbv}, 32'h0);
        chk("t6_rst_wbd", {16'h0, a_wbd}, 32'h0);
        chk("t6_rst_fc", {30'h0, a_fc}, 32'h0);
        reset = 1'b1; a_ack = 1'b1; a_rdata = 16'hBEEF;
        tick(); a_ack = 1'b0;
        chk("t6_late_wbv", {31'h0, a_wbv}, 32'h0);
        chk("t6_late_req", {31'h0, a_req}, 32'h0);

        // 6b: 32-bit word load, byte load at lane 3, half store at lane 2
        b_issue(1'b1, 1'b0, 2'd2, 1'b0, 2'd2, 16'h0004, 32'h0);
        tick(); b_in_valid = 1'b0;
        chk("t6w_addr", {16'h0, b_addr}, 32'h0004);
        chk("t6w_be", {28'h0, b_be}, 32'hF);
        chk("t6w_req", {31'h0, b_req}, 32'h1);
        b_ack = 1'b1; b_rdata = 32'hDEADBEEF;
        tick(); b_ack = 1'b0;
        chk("t6w_wbv", {31'h0, b_wbv}, 32'h1);
        chk("t6w_wbd", b_wbd, 32'hDEADBEEF);
        b_issue(1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 16'h0007, 32'h0);
        tick(); b_in_valid = 1'b0;
        chk("t6b_addr", {16'h0, b_addr}, 32'h0004);
        b_ack = 1'b1; b_rdata = 32'h80112233;
        tick(); b_ack = 1'b0;
        chk("t6b_wbd", b_wbd, 32'hFFFFFF80);
        b_issue(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 16'h0006, 32'h0000ABCD);
        tick(); b_in_valid = 1'b0;
        chk("t6h_be", {28'h0, b_be}, 32'hC);
        chk("t6h_wdata", b_wdata, 32'hABCDABCD);
        chk("t6h_we", {31'h0, b_we}, 32'h1);
        b_ack = 1'b1;
        tick(); b_ack = 1'b0;
        chk("t6h_wbv", {31'h0, b_wbv}, 32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
